// File: rtl/note_sequencer_pkg.sv
// Shared definitions for the note sequencer: FSM state encoding, rest code
// and the note-to-phase-increment table function.
package note_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GATE_ON  = 2'd1,
        GATE_OFF = 2'd2
    } seq_state_e;

    localparam logic [3:0] NOTE_REST = 4'd15;

    // Phase increment for note idx: trunc(f * 2^(frac_bits+1) / 31250), where
    // frac_bits = BITDEPTH + BITFRACTION. Frequencies are held in micro-hertz so
    // the whole computation stays in integer arithmetic. Results that do not
    // fit the 16-bit increment clamp to the largest representable step.
    function automatic logic [15:0] note_increment(input logic [3:0] idx,
                                                   input int unsigned frac_bits);
        logic [63:0] base_uhz;
        logic [63:0] v;
        int unsigned octave;
        octave = (idx >= 4'd14) ? 2 : ((idx >= 4'd7) ? 1 : 0);
        case (idx)
            4'd0, 4'd7, 4'd14: base_uhz = 64'd261625565; // C
            4'd1, 4'd8:        base_uhz = 64'd293664768; // D
            4'd2, 4'd9:        base_uhz = 64'd329627557; // E
            4'd3, 4'd10:       base_uhz = 64'd349228231; // F
            4'd4, 4'd11:       base_uhz = 64'd391995436; // G
            4'd5, 4'd12:       base_uhz = 64'd440000000; // A
            4'd6, 4'd13:       base_uhz = 64'd493883301; // B
            default:           base_uhz = 64'd0;         // rest
        endcase
        v = (base_uhz << (octave + frac_bits + 1)) / 64'd31250000000;
        return (v > 64'd65535) ? 16'hFFFF : v[15:0];
    endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Control, pattern-write and playback-output bundle of the note sequencer.
interface note_sequencer_if #(
    parameter int SW = 4
);
    logic          start;
    logic          stop;
    logic [SW-1:0] last_step;
    logic [15:0]   step_len;
    logic [15:0]   gate_len;
    logic          wr_en;
    logic [SW-1:0] wr_addr;
    logic [3:0]    wr_note;
    logic [15:0]   increment;
    logic          gate;
    logic [SW-1:0] step;
    logic          running;

    modport master (
        output start, stop, last_step, step_len, gate_len, wr_en, wr_addr, wr_note,
        input  increment, gate, step, running
    );

    modport slave (
        input  start, stop, last_step, step_len, gate_len, wr_en, wr_addr, wr_note,
        output increment, gate, step, running
    );
endinterface

// File: rtl/note_sequencer_seq_pattern_ram.sv
// Pattern storage: STEPS x 4-bit notes, one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module seq_pattern_ram #(
    parameter int STEPS = 16,
    parameter int SW    = $clog2(STEPS)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [SW-1:0] wr_addr,
    input  logic [3:0]    wr_data,
    input  logic [SW-1:0] rd_addr,
    output logic [3:0]    rd_data
);
    logic [3:0] mem_q [STEPS];

    // Store the written note; visible to reads from the next clock on.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/note_sequencer.sv
// Step sequencer: plays a programmable note pattern at a tempo counted in
// sample_clock ticks, producing a phase increment and a gate per step.
// Optional feature macro: SEQ_TRANSPOSE_EN adds octave_up (one octave up,
// saturating, sampled when a note is latched).
module note_sequencer
    import note_sequencer_pkg::*;
#(
    parameter int BITDEPTH    = 14,
    parameter int BITFRACTION = 6,
    parameter int STEPS       = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_clock,
`ifdef SEQ_TRANSPOSE_EN
    input  logic octave_up,
`endif
    note_sequencer_if.slave bus
);
    localparam int SW = $clog2(STEPS);

    seq_state_e    state_q, state_d;
    logic [SW-1:0] step_q, step_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   inc_q, inc_d;
    logic [3:0]    note_q, note_d;
    logic          sc_q;
    logic          tick;
    logic          latch;
    logic [3:0]    ram_note;
    logic [15:0]   table_inc;
    logic [15:0]   new_inc;
    logic [15:0]   step_eff;
    logic [15:0]   gate_eff;
    logic [15:0]   on_ticks;
    logic [16:0]   cnt_inc;
    logic [15:0]   inc_table [16];

    for (genvar i = 0; i < 16; i++) begin : g_tbl
        assign inc_table[i] = note_increment(4'(i), BITDEPTH + BITFRACTION);
    end

`ifdef SEQ_TRANSPOSE_EN
    function automatic logic [15:0] octave_shift(input logic [15:0] v);
        return v[15] ? 16'hFFFF : {v[14:0], 1'b0};
    endfunction
    assign table_inc = inc_table[ram_note];
    assign new_inc   = octave_up ? octave_shift(table_inc) : table_inc;
`else
    assign table_inc = inc_table[ram_note];
    assign new_inc   = table_inc;
`endif

    // The RAM is read at the step being entered so the note can be latched on that edge.
    seq_pattern_ram #(.STEPS(STEPS), .SW(SW)) u_ram (
        .clk    (clk),
        .wr_en  (bus.wr_en),
        .wr_addr(bus.wr_addr),
        .wr_data(bus.wr_note),
        .rd_addr(step_d),
        .rd_data(ram_note)
    );

    assign tick     = sample_clock & ~sc_q;
    // Very short steps stretch to 2 ticks and the gate is kept at least one
    // tick shorter than the step, so the envelope always sees a low period.
    assign step_eff = (bus.step_len < 16'd2) ? 16'd2 : bus.step_len;
    assign gate_eff = (bus.gate_len == 16'd0) ? 16'd1 : bus.gate_len;
    assign on_ticks = (gate_eff < step_eff) ? gate_eff : (step_eff - 16'd1);
    assign cnt_inc  = {1'b0, cnt_q} + 17'd1;

    // State, counters and latched note; cleared asynchronously (pattern RAM excepted).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            cnt_q   <= '0;
            inc_q   <= '0;
            note_q  <= '0;
            sc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            inc_q   <= inc_d;
            note_q  <= note_d;
            sc_q    <= sample_clock;
        end
    end

    // Next state: stop beats start, start (re)starts at step 0, ticks drive the step.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        if (bus.stop) begin
            state_d = IDLE;
        end else if (bus.start) begin
            state_d = GATE_ON;
            step_d  = '0;
            cnt_d   = '0;
            latch   = 1'b1;
        end else begin
            case (state_q)
                GATE_ON: begin
                    if (tick) begin
                        cnt_d = cnt_inc[15:0];
                        if (cnt_inc >= {1'b0, on_ticks}) state_d = GATE_OFF;
                    end
                end
                GATE_OFF: begin
                    if (tick) begin
                        if (cnt_inc >= {1'b0, step_eff}) begin
                            state_d = GATE_ON;
                            step_d  = (step_q == bus.last_step) ? '0 : SW'(step_q + 1'b1);
                            cnt_d   = '0;
                            latch   = 1'b1;
                        end else begin
                            cnt_d = cnt_inc[15:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Note latch: a rest keeps the previous increment so release tails keep pitch.
    always_comb begin
        note_d = note_q;
        inc_d  = inc_q;
        if (latch) begin
            note_d = ram_note;
            if (ram_note != NOTE_REST) inc_d = new_inc;
        end
    end

    // Outputs: gate only while in the on-phase of a non-rest step.
    always_comb begin
        bus.gate      = (state_q == GATE_ON) && (note_q != NOTE_REST);
        bus.running   = (state_q != IDLE);
        bus.increment = inc_q;
        bus.step      = step_q;
    end
endmodule
